flag_reg_stack: RTL and testbench
=================================

Name: flag_reg_stack

Overview:
- Parametrised successor of the processor status-flag register: holds NUM_FLAGS condition flags (C, OV, P, Z, S by default).
- Adds per-flag ALU update enables, explicit set/clear masks (STC/CLC-style), direct load (POPF), and a hardware flag stack of STACK_DEPTH entries for interrupt entry/return.
- Sits between ALU flag outputs and control unit / branch logic.

Parameters:
- NUM_FLAGS, 5: number of flag bits; bit order C=0, OV=1, P=2, Z=3, S=4, any extra bits user-defined.
- STACK_DEPTH, 4: number of saved flag words; must be >= 1.
- LVL_W, $clog2(STACK_DEPTH+1): width of stack_level (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- upd_en  in  NUM_FLAGS  per-flag ALU update enable (generalises C_OV_en).
- flags_in  in  NUM_FLAGS  ALU flag results.
- set_mask  in  NUM_FLAGS  force flag to 1.
- clr_mask  in  NUM_FLAGS  force flag to 0.
- load_en  in  1  load whole flag word from load_val.
- load_val  in  NUM_FLAGS  word for load_en.
- push  in  1  save current flags to stack.
- pop  in  1  restore flags from stack top.
- err_clr  in  1  clear sticky stack_err.
- flags_out  out  NUM_FLAGS  registered flag word.
- stack_level  out  LVL_W  number of valid stack entries.
- stack_empty  out  1  stack_level == 0.
- stack_full  out  1  stack_level == STACK_DEPTH.
- stack_err  out  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (rst=0, asynchronous): flags_out=0, stack_level=0, stack_err=0, stack_empty=1, stack_full=0. Stack storage contents don't-care.
- Release of reset is synchronised by the integrator; the block takes no action on the first edge beyond normal operation.
- All updates take effect at the next rising clk edge; flags_out and the status outputs are registered. Latency is 1 cycle. There is no combinational path from any input to flags_out.
- Flag-word priority per cycle, highest first:
  - valid pop: flags_out <= stack top.
  - load_en: flags_out <= load_val.
  - per bit: clr_mask wins over set_mask, and set_mask/clr_mask win over upd_en.
  - per bit with upd_en=1: flag <= flags_in.
  - otherwise: bit holds.
- push alone, not full: stack[level] <= flags_out as it was before this edge (pre-update value), level+1. Same-cycle ALU/load/set/clr updates still apply to flags_out.
- push when full: no write, level unchanged, stack_err <= 1; other flag sources still apply.
- pop alone, not empty: level-1 and flags_out <= stack[level-1].
- pop when empty: stack_err <= 1, level unchanged; the pop is treated as invalid and lower-priority sources apply.
- push and pop in the same cycle, not empty: exchange. flags_out <= top entry, top entry <= old flags_out, level unchanged.
- push and pop in the same cycle, empty: stack_err <= 1, nothing pushed, lower-priority sources apply.
- stack_err is sticky until err_clr. If err_clr and a new error occur in the same cycle, the new error wins and stack_err = 1.
- stack_empty and stack_full are derived from the registered level; they are never asserted simultaneously.

Decomposition:
- Shared package flagi_pkg:
  - flag index constants FLAG_C=0, FLAG_OV=1, FLAG_P=2, FLAG_Z=3, FLAG_S=4.
  - default NUM_FLAGS.
  - typedef flags_t (logic [NUM_FLAGS-1:0]).
- One natural sub-module, flag_lifo: parametrised LIFO (push/pop/exchange, level, full/empty).
- Top-level flag_reg_stack keeps the priority mux and the sticky error.

Test Plan:
- Reset: drive rst=0 mid-operation with flags=5'b10101, level=2 -> outputs clear immediately (before the next edge): flags_out=0, level=0, empty=1, err=0.
- Per-flag update: upd_en=5'b00011, flags_in=5'b11111 -> flags_out=5'b00011 one cycle later. Then set_mask=5'b01000 and clr_mask=5'b01001 with upd_en=all, flags_in=all ones -> 5'b10110 (clear wins on bit 3).
- Push/pop, STACK_DEPTH=4:
  - push 5'b00001, 5'b00010, 5'b00100, 5'b01000 -> full=1, level=4.
  - 5th push -> err=1, level=4.
  - 4 pops return 5'b01000, 5'b00100, 5'b00010, 5'b00001 in that order; empty=1.
- Underflow: pop with empty stack and load_en=1, load_val=5'b11000 -> flags_out=5'b11000, err=1, level=0. Then err_clr -> err=0.
- Exchange: stack top=5'b00101, flags_out=5'b10010, push=pop=1 -> flags_out=5'b00101, top=5'b10010, level unchanged.
- Push with same-cycle ALU update: flags_out=5'b00001, push=1, upd_en=all, flags_in=5'b11110 -> stack gets 5'b00001, flags_out=5'b11110.

Source files
------------

// File: rtl/flagi_pkg.sv
// Shared definitions for the status-flag register and its save stack.
// Flag bit positions follow the legacy status register layout.
package flagi_pkg;

    localparam int NUM_FLAGS_DEF = 5;

    localparam int FLAG_C  = 0;
    localparam int FLAG_OV = 1;
    localparam int FLAG_P  = 2;
    localparam int FLAG_Z  = 3;
    localparam int FLAG_S  = 4;

    typedef logic [NUM_FLAGS_DEF-1:0] flags_t;

    // Width of a fill counter that must represent 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flag_lifo.sv
// Small LIFO holding saved flag words for interrupt entry/return.
// Supports push, pop and same-cycle exchange. Illegal requests
// (push when full without pop, pop when empty) leave the stack untouched
// and are reported through err_evt for the owner to latch.
module flag_lifo
    import flagi_pkg::*;
#(
    parameter  int WIDTH = NUM_FLAGS_DEF,
    parameter  int DEPTH = 4,
    localparam int LVL_W = lvl_width(DEPTH),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             pop_ok,
    output logic             err_evt,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [LVL_W-1:0] level_r;

    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             do_xchg_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] wr_idx_s;

    // Decode the request against the current fill level.
    always_comb begin
        full_s    = (level_r == LVL_W'(DEPTH));
        empty_s   = (level_r == {LVL_W{1'b0}});
        do_push_s = push & ~pop & ~full_s;
        do_pop_s  = pop & ~push & ~empty_s;
        do_xchg_s = push & pop & ~empty_s;
        err_evt   = (push & ~pop & full_s) | (pop & empty_s);
        if (empty_s) begin
            top_idx_s = {IDX_W{1'b0}};
        end else begin
            top_idx_s = IDX_W'(level_r - LVL_W'(1));
        end
        if (do_xchg_s) begin
            wr_idx_s = top_idx_s;
        end else begin
            wr_idx_s = IDX_W'(level_r);
        end
    end

    // Storage write: new entry on push, overwrite top on exchange.
    always_ff @(posedge clk) begin
        if (do_push_s || do_xchg_s) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

    // Fill level; exchange and illegal requests leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {LVL_W{1'b0}};
        end else if (do_push_s) begin
            level_r <= level_r + LVL_W'(1);
        end else if (do_pop_s) begin
            level_r <= level_r - LVL_W'(1);
        end else begin
            level_r <= level_r;
        end
    end

    assign rd_data = mem_r[top_idx_s];
    assign pop_ok  = do_pop_s | do_xchg_s;
    assign level   = level_r;
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/flag_reg_stack.sv
// Processor status-flag register with per-flag ALU update enables,
// set/clear masks, whole-word load and a hardware save stack.
// Priority per cycle: valid pop > load > clear > set > ALU update > hold.
module flag_reg_stack
    import flagi_pkg::*;
#(
    parameter  int NUM_FLAGS   = NUM_FLAGS_DEF,
    parameter  int STACK_DEPTH = 4,
    localparam int LVL_W       = lvl_width(STACK_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FLAGS-1:0] upd_en,
    input  logic [NUM_FLAGS-1:0] flags_in,
    input  logic [NUM_FLAGS-1:0] set_mask,
    input  logic [NUM_FLAGS-1:0] clr_mask,
    input  logic                 load_en,
    input  logic [NUM_FLAGS-1:0] load_val,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic [NUM_FLAGS-1:0] flags_out,
    output logic [LVL_W-1:0]     stack_level,
    output logic                 stack_empty,
    output logic                 stack_full,
    output logic                 stack_err
);

    logic [NUM_FLAGS-1:0] flags_r;
    logic [NUM_FLAGS-1:0] flags_nxt_s;
    logic [NUM_FLAGS-1:0] top_s;
    logic                 pop_ok_s;
    logic                 err_evt_s;
    logic                 err_r;
    logic                 err_nxt_s;

    // The stack always saves the flag word as it was before this edge.
    flag_lifo #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (flags_r),
        .rd_data (top_s),
        .pop_ok  (pop_ok_s),
        .err_evt (err_evt_s),
        .level   (stack_level),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    // Flag-word priority mux; within the masks, clear beats set beats ALU.
    always_comb begin
        flags_nxt_s = flags_r;
        if (pop_ok_s) begin
            flags_nxt_s = top_s;
        end else if (load_en) begin
            flags_nxt_s = load_val;
        end else begin
            flags_nxt_s = (((flags_r & ~upd_en) | (flags_in & upd_en)) | set_mask)
                          & ~clr_mask;
        end
    end

    // Sticky error: a new error in the same cycle overrides err_clr.
    always_comb begin
        err_nxt_s = err_r;
        if (err_evt_s) begin
            err_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Flag and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_r <= {NUM_FLAGS{1'b0}};
            err_r   <= 1'b0;
        end else begin
            flags_r <= flags_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign flags_out = flags_r;
    assign stack_err = err_r;

endmodule

// File: tb/tb_flag_reg_stack.sv
// Directed self-checking bench for flag_reg_stack (default parameters).
module tb_flag_reg_stack;

    logic       clk;
    logic       rst;
    logic [4:0] upd_en;
    logic [4:0] flags_in;
    logic [4:0] set_mask;
    logic [4:0] clr_mask;
    logic       load_en;
    logic [4:0] load_val;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [4:0] flags_out;
    logic [2:0] stack_level;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int n_checks = 0;
    int n_errors = 0;

    flag_reg_stack #(.NUM_FLAGS(5), .STACK_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_en      (upd_en),
        .flags_in    (flags_in),
        .set_mask    (set_mask),
        .clr_mask    (clr_mask),
        .load_en     (load_en),
        .load_val    (load_val),
        .push        (push),
        .pop         (pop),
        .err_clr     (err_clr),
        .flags_out   (flags_out),
        .stack_level (stack_level),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        upd_en   = 5'b00000;
        flags_in = 5'b00000;
        set_mask = 5'b00000;
        clr_mask = 5'b00000;
        load_en  = 1'b0;
        load_val = 5'b00000;
        push     = 1'b0;
        pop      = 1'b0;
        err_clr  = 1'b0;
    endtask

    // One clock edge, then return 1 time unit later with inputs idled.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_load(input logic [4:0] v, input logic p);
        load_en  = 1'b1;
        load_val = v;
        push     = p;
        step();
    endtask

    task automatic check_stat(input string tag, input logic [4:0] f, input logic [2:0] lvl,
                              input logic emp, input logic ful, input logic err);
        check_eq({tag, "_flags"}, 32'(flags_out), 32'(f));
        check_eq({tag, "_level"}, 32'(stack_level), 32'(lvl));
        check_eq({tag, "_empty"}, 32'(stack_empty), 32'(emp));
        check_eq({tag, "_full"},  32'(stack_full), 32'(ful));
        check_eq({tag, "_err"},   32'(stack_err), 32'(err));
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #12;
        check_stat("reset", 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_stat("post_reset", 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0);

        // Per-flag ALU update
        upd_en = 5'b00011; flags_in = 5'b11111; step();
        check_eq("upd_partial", 32'(flags_out), 32'(5'b00011));
        // Clear beats set beats ALU
        upd_en = 5'b11111; flags_in = 5'b11111; set_mask = 5'b01000; clr_mask = 5'b01001; step();
        check_eq("set_clr_prio", 32'(flags_out), 32'(5'b10110));
        // Set mask alone on a held bit, ALU on another
        upd_en = 5'b00010; flags_in = 5'b00000; set_mask = 5'b00001; step();
        check_eq("set_and_upd", 32'(flags_out), 32'(5'b10101));

        // Fill the stack: each push saves the pre-update flags
        do_load(5'b00001, 1'b0);
        do_load(5'b00010, 1'b1);
        check_eq("push1_level", 32'(stack_level), 32'd1);
        do_load(5'b00100, 1'b1);
        do_load(5'b01000, 1'b1);
        push = 1'b1; step();
        check_stat("full", 5'b01000, 3'd4, 1'b0, 1'b1, 1'b0);
        // Overflow, same-cycle set still applies
        push = 1'b1; set_mask = 5'b10000; step();
        check_stat("overflow", 5'b11000, 3'd4, 1'b0, 1'b1, 1'b1);
        err_clr = 1'b1; step();
        check_eq("err_clr1", 32'(stack_err), 32'd0);

        // Pops in LIFO order; pop beats load
        pop = 1'b1; load_en = 1'b1; load_val = 5'b11111; step();
        check_eq("pop1", 32'(flags_out), 32'(5'b01000));
        check_eq("pop1_level", 32'(stack_level), 32'd3);
        pop = 1'b1; step();
        check_eq("pop2", 32'(flags_out), 32'(5'b00100));
        pop = 1'b1; step();
        check_eq("pop3", 32'(flags_out), 32'(5'b00010));
        pop = 1'b1; step();
        check_stat("pop4", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);

        // Underflow: invalid pop, load applies
        pop = 1'b1; load_en = 1'b1; load_val = 5'b11000; step();
        check_stat("underflow", 5'b11000, 3'd0, 1'b1, 1'b0, 1'b1);
        err_clr = 1'b1; step();
        check_eq("err_clr2", 32'(stack_err), 32'd0);

        // Exchange
        do_load(5'b00101, 1'b0);
        do_load(5'b10010, 1'b1);
        push = 1'b1; pop = 1'b1; step();
        check_stat("xchg", 5'b00101, 3'd1, 1'b0, 1'b0, 1'b0);
        pop = 1'b1; step();
        check_stat("xchg_top", 5'b10010, 3'd0, 1'b1, 1'b0, 1'b0);

        // Push with same-cycle ALU update
        do_load(5'b00001, 1'b0);
        push = 1'b1; upd_en = 5'b11111; flags_in = 5'b11110; step();
        check_eq("push_alu_flags", 32'(flags_out), 32'(5'b11110));
        check_eq("push_alu_level", 32'(stack_level), 32'd1);
        pop = 1'b1; step();
        check_eq("push_alu_saved", 32'(flags_out), 32'(5'b00001));

        // Push+pop on empty stack: error, load applies, nothing pushed
        push = 1'b1; pop = 1'b1; load_en = 1'b1; load_val = 5'b01010; step();
        check_stat("pp_empty", 5'b01010, 3'd0, 1'b1, 1'b0, 1'b1);
        err_clr = 1'b1; step();
        // New error beats err_clr
        pop = 1'b1; err_clr = 1'b1; step();
        check_eq("err_vs_clr", 32'(stack_err), 32'd1);

        // Async reset mid-operation
        do_load(5'b10101, 1'b0);
        push = 1'b1; step();
        push = 1'b1; step();
        check_stat("pre_reset", 5'b10101, 3'd2, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_stat("async_reset", 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
